piso_serializer: RTL

- Parallel-in, serial-out stage that sits directly upstream of the serial-in/serial-out shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on so.
- so drives the downstream si input.
- Supports back-to-back words with no idle gap, so the serial stream stays continuous.

---
 rtl/piso_pkg.sv | 17 +
 rtl/piso_bit_counter.sv | 30 +++
 rtl/piso_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
// Holds the FSM state encoding and the bit-counter width helper.
// No logic; imported by piso_serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Bits needed to count WIDTH-1 down to 0; never less than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the remaining bits of a serial frame.
// Latency: cnt updates one cycle after load/en; last is combinational on cnt.
// Backpressure: none; load wins over en, and cnt holds at zero instead of wrapping.
// Ports: clk, rst_n (async active-low), load/load_val (reload), en (decrement),
//        cnt (current count), last (cnt == 0).
module piso_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a WIDTH-bit word and emits it one bit per clock on so.
// Latency: first bit on so the cycle after acceptance; frame is WIDTH cycles (WIDTH+1 with parity).
// Backpressure: din_ready only while idle, on the final data bit, or on the parity bit (gapless reload).
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after the data bits.
// Ports: clk, rst_n (async active-low), din/din_valid/din_ready (word handshake),
//        so/so_valid (serial stream to downstream si), busy (frame in progress).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
    localparam bit            PAR_EN   = 1'b1;
`else
    localparam bit            PAR_EN   = 1'b0;
`endif

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic             so_q;
    logic             so_valid_q;
    logic             busy_q;
    logic [CW-1:0]    bit_cnt;
    logic             bit_last;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    // Bit currently at the output end of a word, honouring the shift direction.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Word after one shift toward the output end, zero filled.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // With parity on, the final data bit must not accept: the parity bit still follows.
    always_comb begin
        din_ready = 1'b0;
        case (state)
            ST_IDLE:  din_ready = 1'b1;
            ST_SHIFT: din_ready = (bit_cnt == '0) && !PAR_EN;
            ST_PAR:   din_ready = 1'b1;
            default:  din_ready = 1'b0;
        endcase
    end

    assign accept = din_valid && din_ready;

    piso_bit_counter #(.CW(CW)) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (LOAD_VAL),
        .en       (state == ST_SHIFT),
        .cnt      (bit_cnt),
        .last     (bit_last)
    );

    // The shift register always holds the unsent remainder with the bit on so at
    // its head, so so is registered from the same value that is loaded/shifted.
    // An accept can only occur where din_ready is high, so it takes priority everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else if (accept) begin
            state      <= ST_SHIFT;
            sreg       <= din;
            so_q       <= head(din);
            so_valid_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q      <= ^din;
`endif
        end else if ((state == ST_SHIFT) && !bit_last) begin
            sreg <= advance(sreg);
            so_q <= head(advance(sreg));
`ifdef PISO_PARITY_EN
        end else if (state == ST_SHIFT) begin
            state <= ST_PAR;
            sreg  <= '0;
            so_q  <= par_q;
`endif
        end else begin
            state      <= ST_IDLE;
            sreg       <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end
    end

    assign so       = so_q;
    assign so_valid = so_valid_q;
    assign busy     = busy_q;

endmodule
